// File: rtl/switch_box_config_loader.sv
// Streams 8-bit words into a shadow register and commits them atomically to a switch box config_in.
// Optional XOR checksum word is enabled by defining SWITCH_BOX_CONFIG_LOADER_CHECKSUM_EN.
module switch_box_config_loader #(
  parameter int CONFIG_WIDTH = 264,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                    clock,
  input  logic                    nreset,
  input  logic                    start,
  input  logic [WORD_WIDTH-1:0]   word_in,
  input  logic                    word_valid,
  output logic                    word_ready,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    config_done,
  output logic                    config_error,
  output logic                    busy
);

  localparam int NUM_WORDS = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int SHADOW_W  = NUM_WORDS * WORD_WIDTH;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);

`ifdef SWITCH_BOX_CONFIG_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd3
  } state_e;
`endif

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SHADOW_W-1:0]     shadow_q, shadow_d;
  logic [CONFIG_WIDTH-1:0] config_q, config_d;
  logic                    done_q, done_d;
`ifdef SWITCH_BOX_CONFIG_LOADER_CHECKSUM_EN
  logic [WORD_WIDTH-1:0]   csum_q, csum_d;
  logic                    error_q, error_d;
`endif

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      config_q <= '0;
      done_q   <= 1'b0;
`ifdef SWITCH_BOX_CONFIG_LOADER_CHECKSUM_EN
      csum_q   <= '0;
      error_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      config_q <= config_d;
      done_q   <= done_d;
`ifdef SWITCH_BOX_CONFIG_LOADER_CHECKSUM_EN
      csum_q   <= csum_d;
      error_q  <= error_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    config_d = config_q;
    done_d   = done_q;
`ifdef SWITCH_BOX_CONFIG_LOADER_CHECKSUM_EN
    csum_d   = csum_q;
    error_d  = error_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = LOAD;
          cnt_d    = '0;
          shadow_d = '0;
          done_d   = 1'b0;
`ifdef SWITCH_BOX_CONFIG_LOADER_CHECKSUM_EN
          csum_d   = '0;
          error_d  = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (word_valid) begin
          for (int k = 0; k < NUM_WORDS; k++) begin
            if (cnt_q == CNT_W'(k)) begin
              shadow_d[k*WORD_WIDTH +: WORD_WIDTH] = word_in;
            end
          end
`ifdef SWITCH_BOX_CONFIG_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ word_in;
`endif
          // The counter holds at the last index instead of wrapping.
          if (cnt_q == LAST_WORD) begin
`ifdef SWITCH_BOX_CONFIG_LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = COMMIT;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef SWITCH_BOX_CONFIG_LOADER_CHECKSUM_EN
      CHECK: begin
        if (word_valid) begin
          if (word_in == csum_q) begin
            state_d = COMMIT;
          end else begin
            error_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif
      COMMIT: begin
        config_d = shadow_q[CONFIG_WIDTH-1:0];
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef SWITCH_BOX_CONFIG_LOADER_CHECKSUM_EN
  assign word_ready   = (state_q == LOAD) || (state_q == CHECK);
  assign config_error = error_q;
`else
  assign word_ready   = (state_q == LOAD);
  assign config_error = 1'b0;
`endif
  assign busy        = (state_q != IDLE);
  assign config_out  = config_q;
  assign config_done = done_q;

endmodule
